// File: rtl/multi_byte_add_ctrl_if.sv
// Handshake and operand/result bundle for the byte-serial adder.
// The master drives requests; the slave (the adder controller) returns results.
interface multi_byte_add_ctrl_if #(
  parameter int unsigned NBYTES = 4
) ();
  logic                  start;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  cin;
  logic                  ready;
  logic                  done;
  logic [8*NBYTES-1:0]   sum;
  logic                  cout;
  logic                  ovf;
  logic                  valid;

  modport master (
    output start, a, b, cin,
    input  ready, done, sum, cout, ovf, valid
  );

  modport slave (
    input  start, a, b, cin,
    output ready, done, sum, cout, ovf, valid
  );
endinterface

// File: rtl/eight_bit_adder.sv
// Combinational 8-bit adder with carry-in and carry-out.
module eight_bit_adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Carry
);
  assign {Carry, Sum} = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
endmodule

// File: rtl/multi_byte_add_ctrl.sv
// Byte-serial multi-byte adder: one shared 8-bit adder processes one byte per cycle,
// rippling the carry through a register, with ready/done/valid handshaking.
module multi_byte_add_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_byte_add_ctrl_if.slave  bus
);
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned Msb  = 8 * NBYTES - 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic                carry_q;
  logic [8*NBYTES-1:0] a_q;
  logic [8*NBYTES-1:0] b_q;
  logic [8*NBYTES-1:0] sum_q;
  logic                cout_q;
  logic                ovf_q;
  logic                valid_q;
  logic                done_q;
  logic                ready_q;

  logic [IdxW+2:0]     bit_base;
  logic [7:0]          add_a;
  logic [7:0]          add_b;
  logic [7:0]          add_sum;
  logic                add_carry;

  assign bit_base = {idx_q, 3'b000};
  // Operand mux follows the latched operands and index, so it holds still outside RUN.
  assign add_a    = a_q[bit_base +: 8];
  assign add_b    = b_q[bit_base +: 8];

  eight_bit_adder u_adder (
    .A     (add_a),
    .B     (add_b),
    .Cin   (carry_q),
    .Sum   (add_sum),
    .Carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          sum_q[bit_base +: 8] <= add_sum;
          carry_q              <= add_carry;
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            cout_q  <= add_carry;
            ovf_q   <= (a_q[Msb] == b_q[Msb]) && (add_sum[7] != a_q[Msb]);
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_multi_byte_add_ctrl.sv
// Directed self-checking bench for the byte-serial adder controller, NBYTES=4.
module tb_multi_byte_add_ctrl;
  localparam int unsigned NBYTES = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  multi_byte_add_ctrl_if #(.NBYTES(NBYTES)) bus ();

  multi_byte_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 20);
  endtask

  task automatic test_reset();
    tests++;
    if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    tests++;
    if (bus.valid !== 1'b0 || bus.done !== 1'b0) begin
      fails++; $display("FAIL reset_valid_done got %b%b want 00", bus.valid, bus.done);
    end
    tests++;
    if (bus.sum !== 32'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      fails++; $display("FAIL reset_result got sum=%h cout=%b ovf=%b want 0", bus.sum, bus.cout, bus.ovf);
    end
  endtask

  // Starts in the #1-after-edge slot; returns in the slot after done has been checked.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] esum, input logic ecout,
                        input logic eovf);
    int n;
    logic [31:0] s;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
    tests++;
    if (bus.ready !== 1'b0 || bus.valid !== 1'b0) begin
      fails++; $display("FAIL %s_run_flags got ready=%b valid=%b want 0 0", name, bus.ready, bus.valid);
    end
    wait_done(n);
    tests++;
    if (n !== NBYTES) begin fails++; $display("FAIL %s_latency got %0d want %0d", name, n, NBYTES); end
    tests++;
    if (bus.sum !== esum || bus.cout !== ecout || bus.ovf !== eovf || bus.valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_result got sum=%h cout=%b ovf=%b valid=%b want sum=%h cout=%b ovf=%b valid=1",
               name, bus.sum, bus.cout, bus.ovf, bus.valid, esum, ecout, eovf);
    end
    s = bus.sum;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b0 || bus.valid !== 1'b1 || bus.ready !== 1'b1 || bus.sum !== s) begin
      fails++;
      $display("FAIL %s_idle_hold got done=%b valid=%b ready=%b sum=%h want 0 1 1 %h",
               name, bus.done, bus.valid, bus.ready, bus.sum, s);
    end
  endtask

  task automatic test_carry_chain();
    run_op("carry_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_ripple();
    run_op("ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [31:0] s;
    pulses = 0;
    s = '0;
    bus.start = 1'b1; bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'hAAAA_AAAA; bus.b = 32'h5555_5555; bus.cin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin pulses++; s = bus.sum; end
      @(posedge clk); #1;
    end
    tests++;
    if (pulses !== 1) begin fails++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    tests++;
    if (s !== 32'h3333_3333) begin fails++; $display("FAIL ignore_sum got %h want 33333333", s); end
    tests++;
    if (bus.sum !== 32'h3333_3333 || bus.ready !== 1'b1 || bus.valid !== 1'b1) begin
      fails++;
      $display("FAIL ignore_final got sum=%h ready=%b valid=%b want 33333333 1 1",
               bus.sum, bus.ready, bus.valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd2; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(n);
    tests++;
    if (bus.done !== 1'b1 || bus.sum !== 32'd3) begin
      fails++; $display("FAIL b2b_first got done=%b sum=%h want 1 3", bus.done, bus.sum);
    end
    bus.start = 1'b1; bus.a = 32'd10; bus.b = 32'd20; bus.cin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests++;
    if (bus.ready !== 1'b0 || bus.valid !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept got ready=%b valid=%b done=%b want 0 0 0",
               bus.ready, bus.valid, bus.done);
    end
    wait_done(n);
    tests++;
    if (n !== NBYTES) begin fails++; $display("FAIL b2b_latency got %0d want %0d", n, NBYTES); end
    tests++;
    if (bus.sum !== 32'd31 || bus.cout !== 1'b0 || bus.ovf !== 1'b0 || bus.valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_result got sum=%0d cout=%b ovf=%b valid=%b want 31 0 0 1",
               bus.sum, bus.cout, bus.ovf, bus.valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    bus.start = 1'b1; bus.a = 32'h0102_0304; bus.b = 32'h1010_1010; bus.cin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (bus.ready !== 1'b0) begin fails++; $display("FAIL arst_midrun_ready got %b want 0", bus.ready); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 32'h0 ||
        bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL arst_outputs got ready=%b valid=%b done=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0 0",
               bus.ready, bus.valid, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.valid) pulses++;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL arst_no_done got %0d active cycles want 0", pulses); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_carry_chain();
    test_overflow();
    test_ripple();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_byte_add_ctrl.md
MULTI_BYTE_ADD_CTRL -- requirements
Module: multi_byte_add_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: requests an addition; sampled only while ready=1.
REQ-005 SHALL have port a, input, 8*NBYTES bits: operand A, unsigned or two's complement.
REQ-006 SHALL have port b, input, 8*NBYTES bits: operand B.
REQ-007 SHALL have port cin, input, 1 bit: carry-in to byte 0.
REQ-008 SHALL have port ready, output, 1 bit: block can accept start.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking result completion.
REQ-010 SHALL have port sum, output, 8*NBYTES bits: result, valid while valid=1.
REQ-011 SHALL have port cout, output, 1 bit: carry out of the most significant byte.
REQ-012 SHALL have port ovf, output, 1 bit: signed overflow flag.
REQ-013 SHALL have port valid, output, 1 bit: sum/cout/ovf hold a completed result.

Function
REQ-014 SHALL instantiate exactly one eight_bit_adder (A, B, Cin, Sum, Carry) as its sole arithmetic element; no other adders or "+" operators on operand data.
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 SHALL assert ready=1 in IDLE and DONE and ready=0 in RUN.
REQ-017 SHALL, on start=1 with ready=1: latch a, b and cin; set byte index=0; load the carry register with cin; clear valid; enter RUN.
REQ-018 SHALL, in RUN: drive the adder with latched A byte[idx], B byte[idx] and the carry register; write the adder Sum into sum byte[idx]; load the adder Carry into the carry register; increment idx.
REQ-019 SHALL, when idx=NBYTES-1 in RUN: enter DONE after that edge.
REQ-020 SHALL, in DONE: assert done=1 for exactly that cycle; set valid=1; set cout=final carry; set ovf=(A msb==B msb) && (sum msb!=A msb).
REQ-021 SHALL, in DONE: go to RUN if start=1 (back-to-back operation, no bubble), else go to IDLE.
REQ-022 SHALL have a latency of NBYTES+1 cycles: start sampled at edge T gives done=1 in the cycle after edge T+NBYTES.
REQ-023 SHALL ignore start while in RUN; latched operands SHALL NOT change and no request SHALL be queued.
REQ-024 SHALL ignore changes on a, b and cin after the accepting edge.
REQ-025 SHALL hold sum, cout, ovf and valid stable in IDLE until the next accepted start.
REQ-026 SHALL leave sum bytes not yet written in RUN undefined-for-use; only valid=1 qualifies the outputs.
REQ-027 SHALL, in IDLE and DONE, hold the adder inputs at their last values; they SHALL NOT affect outputs.

Reset
REQ-028 SHALL, on rst_n=0 (asynchronous, any state including mid-RUN), force FSM=IDLE, idx=0, carry register=0, sum=0, cout=0, ovf=0, valid=0, done=0, ready=1.
REQ-029 SHALL NOT restart or complete an interrupted operation after rst_n deasserts; start SHALL be sampled from the first rising edge with rst_n=1.

Verification
REQ-030 SHALL be covered with NBYTES=4: a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, ovf=0, done 5 cycles after start sampled.
REQ-031 SHALL be covered with NBYTES=4: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; then a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
REQ-032 SHALL be covered with NBYTES=4: a=0x000000FF, b=0x00000001, cin=0 (carry ripple across byte boundary) -> sum=0x00000100, cout=0.
REQ-033 SHALL be covered: start pulsed during RUN with different operands -> ignored; first result unchanged; done pulses once.
REQ-034 SHALL be covered: start held high in DONE cycle with a=10, b=20, cin=1 -> next RUN starts immediately; sum=31 after NBYTES+1 further cycles.
REQ-035 SHALL be covered: rst_n asserted at idx=2 -> all outputs 0, ready=1 immediately (asynchronous), no done pulse afterwards.
